// File: rtl/chess_board_mem.sv
// 8x8 chess board memory: a registered VGA read port, plus a command FSM that
// applies SET/MOVE/MARK/CLEAR_MARKS/RESET_BOARD through an internal port.
module chess_board_mem (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [11:0] chess_address,
  output logic [31:0] chess_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_src,
  input  logic [5:0]  cmd_dst,
  input  logic [3:0]  cmd_arg,
  output logic        cmd_done
);
  typedef enum logic [2:0] {INIT, IDLE, MV_RD, MV_WR_DST, MV_WR_SRC, WR1, SWEEP} state_t;

  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_MOVE  = 3'd2;
  localparam logic [2:0] OP_MARK  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_RESET = 3'd5;

  logic [7:0]  mem [64];
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, src_q, src_d, dst_q, dst_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  arg_q, arg_d;
  logic [7:0]  rd_q, rd_d;
  logic        ready_q, ready_d, done_q, done_d;
  logic [31:0] chess_data_q, chess_data_d;
  logic        mem_we;
  logic [5:0]  mem_waddr, int_addr;
  logic [7:0]  mem_wdata, int_data;

  // Base colour is black on even (row+col), which depends only on the LSBs.
  function automatic logic [3:0] base_sq(input logic [5:0] s);
    return (s[3] ^ s[0]) ? 4'h4 : 4'h8;
  endfunction

  function automatic logic [7:0] init_entry(input logic [5:0] s);
    logic [2:0] ptype;
    logic       pc;
    ptype = 3'd0;
    case (s[5:3])
      3'd0, 3'd7: begin
        case (s[2:0])
          3'd0, 3'd7: ptype = 3'd5;
          3'd1, 3'd6: ptype = 3'd1;
          3'd2, 3'd5: ptype = 3'd4;
          3'd3:       ptype = 3'd3;
          default:    ptype = 3'd2;
        endcase
      end
      3'd1, 3'd6: ptype = 3'd6;
      default:    ptype = 3'd0;
    endcase
    pc = (s[5:3] >= 3'd6);
    return {base_sq(s), ptype, pc};
  endfunction

  always_ff @(posedge iVGA_CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    chess_data_d = 32'd0;
    if (chess_address[11:6] == 6'd0) chess_data_d = {24'd0, mem[chess_address[5:0]]};
  end

  always_comb begin
    int_addr = dst_q;
    if (state_q == MV_RD && op_q == OP_MOVE) int_addr = src_q;
    else if (state_q == SWEEP)               int_addr = cnt_q;
  end

  assign int_data = mem[int_addr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    op_d      = op_q;
    arg_d     = arg_q;
    rd_d      = rd_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = dst_q;
    mem_wdata = 8'h00;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = init_entry(cnt_q);
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          arg_d   = cmd_arg;
          ready_d = 1'b0;
          state_d = (cmd_op == OP_CLEAR || cmd_op == OP_RESET) ? SWEEP : MV_RD;
        end
      end
      // Shared read phase: MOVE captures src, SET/MARK capture dst; others finish here.
      MV_RD: begin
        rd_d = int_data;
        if (op_q == OP_SET || op_q == OP_MARK) begin
          state_d = WR1;
        end else if (op_q == OP_MOVE && src_q != dst_q) begin
          state_d = MV_WR_DST;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_wdata = (op_q == OP_SET) ? {rd_q[7:4], arg_q} : {arg_q, rd_q[3:0]};
        state_d   = IDLE;
        ready_d   = 1'b1;
        done_d    = 1'b1;
      end
      MV_WR_DST: begin
        mem_we    = 1'b1;
        mem_wdata = {int_data[7:4], rd_q[3:0]};
        state_d   = MV_WR_SRC;
      end
      MV_WR_SRC: begin
        mem_we    = 1'b1;
        mem_waddr = src_q;
        mem_wdata = {rd_q[7:4], 4'b0000};
        state_d   = IDLE;
        ready_d   = 1'b1;
        done_d    = 1'b1;
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (op_q == OP_RESET) ? init_entry(cnt_q) : {base_sq(cnt_q), int_data[3:0]};
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = 6'd0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= INIT;
      cnt_q        <= 6'd0;
      src_q        <= 6'd0;
      dst_q        <= 6'd0;
      op_q         <= 3'd0;
      arg_q        <= 4'd0;
      rd_q         <= 8'd0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      chess_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      rd_q         <= rd_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      chess_data_q <= chess_data_d;
    end
  end

  assign chess_data = chess_data_q;
  assign cmd_ready  = ready_q;
  assign cmd_done   = done_q;
endmodule
